instr_imm_encoder: RTL and testbench
====================================

INSTR_IMM_ENCODER -- requirements
Module: instr_imm_encoder

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, giving the instruction-memory write-address width.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: an encode request is present.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept a request.
REQ-006 The block SHALL have ports in_opcode (4 bits), in_ra (4 bits), in_rb (4 bits) and in_imm (16 bits), all inputs: opcode, register fields and the full-width signed immediate.
REQ-007 The block SHALL have ports out_valid (output, 1 bit), out_ready (input, 1 bit), out_instr (output, 16 bits) and out_addr (output, ADDR_W bits): the instruction-memory write stream.
REQ-008 The block SHALL have ports addr_clear (input, 1 bit), err (output, 1 bit) and err_count (output, 8 bits): address restart, range-error pulse and saturating error count.

Function
REQ-009 The block SHALL select the format from in_opcode[3]=1 as IMM4 (instr = opcode, ra, rb, imm[3:0]), from in_opcode=0111 as IMM12 (instr = opcode, imm[11:0]), and from other 0xxx opcodes as IMM8 (instr = opcode, ra, imm[7:0]).
REQ-010 The block SHALL deem an immediate to fit only when sign-extending its low field bits (4, 8 or 12) back to 16 bits reproduces in_imm exactly.
REQ-011 The block SHALL implement FSM states IDLE and HOLD, with in_ready=1 only in IDLE.
REQ-012 In IDLE, a request accepted with a fitting immediate SHALL cause out_instr to be registered, out_valid=1 on the next cycle, and a transition to HOLD, giving one-cycle latency.
REQ-013 In IDLE, a request accepted with a non-fitting immediate SHALL pulse err high for exactly one cycle on the next cycle, increment err_count (saturating at 255), emit no word, and leave the FSM in IDLE.
REQ-014 In HOLD, out_instr and out_addr SHALL remain stable and out_valid SHALL remain 1 until out_ready=1.
REQ-015 On the HOLD handshake, out_valid SHALL drop, out_addr SHALL increment modulo 2^ADDR_W (wrapping from all-ones to 0), and the FSM SHALL return to IDLE.
REQ-016 addr_clear SHALL set out_addr to 0 on the next edge; when it coincides with a handshake, the clear SHALL take priority over the increment; in HOLD, it SHALL not alter the pending word's visible address until that handshake completes.
REQ-017 Sustained throughput SHALL be one word per two cycles when out_ready is held at 1.

Reset
REQ-018 rst SHALL set the FSM to IDLE, out_valid=0, out_instr=0x0000, out_addr=0, err=0 and err_count=0 on the next edge.
REQ-019 rst asserted while in HOLD SHALL discard the pending word with no handshake counted.
REQ-020 rst SHALL take priority over addr_clear and all handshakes.

Structure
REQ-021 A shared package SHALL hold the format enum (IMM4, IMM8, IMM12), the field widths 4/8/12 and the IMM12 opcode constant 4'b0111, reused by the matching sign-extension logic.
REQ-022 A combinational sub-module imm_range_check SHALL take the format and in_imm and return the fit flag and the packed field.

Verification
REQ-023 The bench SHALL check: opcode 0x8, ra=1, rb=2, imm=0xFFF9 (-7) -> out_instr=0x8129 at out_addr 0, one cycle after acceptance.
REQ-024 The bench SHALL check: opcode 0x7, imm=0x0800 (+2048) -> err one-cycle pulse, err_count 0 to 1, no out_valid.
REQ-025 The bench SHALL check: opcode 0x2, ra=3, imm=0xFF80 -> 0x2380; out_ready held at 0 for 5 cycles -> word and address held, in_ready=0 throughout.
REQ-026 The bench SHALL check: ADDR_W=8, 256 fitting requests -> out_addr runs 0..255 and the 257th word lands at 0; addr_clear on a handshake cycle -> next address 0.
REQ-027 The bench SHALL check: 300 out-of-range requests -> err_count saturates at 255; rst asserted in HOLD -> out_valid=0, err_count=0 and out_addr=0 the next cycle.

Source files
------------

// File: rtl/instr_imm_encoder_pkg.sv
// Shared types and constants for the immediate encoder.
// Format select, field widths and sign-extension helper.
package instr_imm_encoder_pkg;

  typedef enum logic [1:0] {
    FMT_IMM4,
    FMT_IMM8,
    FMT_IMM12
  } fmt_e;

  localparam int unsigned IMM4_W  = 4;
  localparam int unsigned IMM8_W  = 8;
  localparam int unsigned IMM12_W = 12;

  localparam logic [3:0] OPC_IMM12 = 4'b0111;

  function automatic fmt_e fmt_of(input logic [3:0] opc);
    fmt_e f;
    f = FMT_IMM8;
    unique case (1'b1)
      opc[3]:             f = FMT_IMM4;
      (opc == OPC_IMM12): f = FMT_IMM12;
      default:            f = FMT_IMM8;
    endcase
    return f;
  endfunction

  function automatic logic [15:0] sext(
    input fmt_e        f,
    input logic [15:0] v
  );
    logic [15:0] r;
    unique case (f)
      FMT_IMM4:
        r = {{(16-IMM4_W){v[IMM4_W-1]}}, v[IMM4_W-1:0]};
      FMT_IMM12:
        r = {{(16-IMM12_W){v[IMM12_W-1]}}, v[IMM12_W-1:0]};
      default:
        r = {{(16-IMM8_W){v[IMM8_W-1]}}, v[IMM8_W-1:0]};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/imm_range_check.sv
// Checks that an immediate fits its field and
// returns the truncated field, zero-padded to 12 bits.
module imm_range_check
  import instr_imm_encoder_pkg::*;
(
  input  fmt_e        fmt_i,
  input  logic [15:0] imm_i,
  output logic        fit_o,
  output logic [11:0] field_o
);

  always_comb begin
    fit_o   = (sext(fmt_i, imm_i) == imm_i);
    field_o = '0;
    unique case (fmt_i)
      FMT_IMM4:  field_o = {8'b0, imm_i[3:0]};
      FMT_IMM12: field_o = imm_i[11:0];
      default:   field_o = {4'b0, imm_i[7:0]};
    endcase
  end

endmodule

// File: rtl/instr_imm_encoder.sv
// Encodes opcode/register/immediate into 16-bit words
// and streams them with an auto-incrementing address.
module instr_imm_encoder
  import instr_imm_encoder_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_opcode,
  input  logic [3:0]        in_ra,
  input  logic [3:0]        in_rb,
  input  logic [15:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  input  logic              addr_clear,
  output logic              err,
  output logic [7:0]        err_count
);

  typedef enum logic {
    S_IDLE,
    S_HOLD
  } state_e;

  state_e             state_q, state_d;
  logic               vld_q, vld_d;
  logic [15:0]        instr_q, instr_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               clrp_q, clrp_d;
  logic               err_q, err_d;
  logic [7:0]         cnt_q, cnt_d;

  fmt_e        fmt;
  logic        fit;
  logic [11:0] field;
  logic [15:0] word;

  assign fmt = fmt_of(in_opcode);

  imm_range_check u_chk (
    .fmt_i   (fmt),
    .imm_i   (in_imm),
    .fit_o   (fit),
    .field_o (field)
  );

  always_comb begin
    word = '0;
    unique case (fmt)
      FMT_IMM4:  word = {in_opcode, in_ra, in_rb, field[3:0]};
      FMT_IMM12: word = {in_opcode, field};
      default:   word = {in_opcode, in_ra, field[7:0]};
    endcase
  end

  always_comb begin
    state_d = state_q;
    vld_d   = vld_q;
    instr_d = instr_q;
    addr_d  = addr_q;
    clrp_d  = clrp_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        clrp_d = 1'b0;
        if (addr_clear) addr_d = '0;
        if (in_valid) begin
          if (fit) begin
            instr_d = word;
            vld_d   = 1'b1;
            state_d = S_HOLD;
          end else begin
            err_d = 1'b1;
            if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
          end
        end
      end
      S_HOLD: begin
        // a clear seen mid-hold is deferred so the pending
        // word keeps its address until it is taken
        if (addr_clear) clrp_d = 1'b1;
        if (out_ready) begin
          vld_d   = 1'b0;
          state_d = S_IDLE;
          clrp_d  = 1'b0;
          if (addr_clear || clrp_q) addr_d = '0;
          else addr_d = addr_q + ADDR_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      vld_q   <= 1'b0;
      instr_q <= '0;
      addr_q  <= '0;
      clrp_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      instr_q <= instr_d;
      addr_q  <= addr_d;
      clrp_q  <= clrp_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = vld_q;
  assign out_instr = instr_q;
  assign out_addr  = addr_q;
  assign err       = err_q;
  assign err_count = cnt_q;

endmodule

// File: tb/tb_instr_imm_encoder.sv
// Scoreboard bench for instr_imm_encoder.
// Expected words queued at drive, popped at handshake.
module tb_instr_imm_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_opcode, in_ra, in_rb;
  logic [15:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [7:0]  out_addr;
  logic        addr_clear;
  logic        err;
  logic [7:0]  err_count;

  int ntest = 0;
  int nerr  = 0;
  int err_seen = 0;
  logic [7:0]  mon_addr = '0;
  logic [15:0] sb_q[$];

  always #5 clk = ~clk;

  instr_imm_encoder #(.ADDR_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_ra      (in_ra),
    .in_rb      (in_rb),
    .in_imm     (in_imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_addr   (out_addr),
    .addr_clear (addr_clear),
    .err        (err),
    .err_count  (err_count)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    ntest++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic void model(
    input  logic [3:0]  opc,
    input  logic [3:0]  ra,
    input  logic [3:0]  rb,
    input  logic [15:0] imm,
    output logic        fit,
    output logic [15:0] w
  );
    int v;
    v = int'($signed(imm));
    if (opc[3]) begin
      fit = (v >= -8) && (v <= 7);
      w   = {opc, ra, rb, imm[3:0]};
    end else if (opc == 4'h7) begin
      fit = (v >= -2048) && (v <= 2047);
      w   = {opc, imm[11:0]};
    end else begin
      fit = (v >= -128) && (v <= 127);
      w   = {opc, ra, imm[7:0]};
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0]  opc,
                       input logic [3:0]  ra,
                       input logic [3:0]  rb,
                       input logic [15:0] imm);
    logic        fit;
    logic [15:0] w;
    int          n;
    model(opc, ra, rb, imm, fit, w);
    in_valid  = 1'b1;
    in_opcode = opc;
    in_ra     = ra;
    in_rb     = rb;
    in_imm    = imm;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    if (fit) sb_q.push_back(w);
    tick();
    in_valid = 1'b0;
  endtask

  function automatic logic [15:0] rnd_fit(input logic [3:0] opc);
    int v;
    if (opc[3])            v = int'($urandom_range(0, 15)) - 8;
    else if (opc == 4'h7)  v = int'($urandom_range(0, 4095)) - 2048;
    else                   v = int'($urandom_range(0, 255)) - 128;
    return 16'(v);
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      mon_addr = '0;
    end else begin
      if (err) err_seen++;
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("spurious_word", 32'(out_instr), 32'hFFFF_FFFF);
        end else begin
          chk("sb_instr", 32'(out_instr), 32'(sb_q.pop_front()));
          chk("sb_addr", 32'(out_addr), 32'(mon_addr));
        end
        mon_addr = addr_clear ? 8'd0 : mon_addr + 8'd1;
      end else if (addr_clear && !out_valid) begin
        mon_addr = '0;
      end
    end
  end

  initial begin
    logic [3:0] opc;
    int         cnt0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    addr_clear = 1'b0;
    in_opcode = '0; in_ra = '0; in_rb = '0; in_imm = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", 32'(out_instr), 32'h0);
    chk("rst_out_addr", 32'(out_addr), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);

    // imm4, -7
    drive(4'h8, 4'h1, 4'h2, 16'hFFF9);
    chk("imm4_valid", 32'(out_valid), 32'd1);
    chk("imm4_instr", 32'(out_instr), 32'h8129);
    chk("imm4_addr", 32'(out_addr), 32'd0);
    tick();
    chk("imm4_drop", 32'(out_valid), 32'd0);

    // imm12 overflow
    drive(4'h7, 4'h0, 4'h0, 16'h0800);
    chk("ovf_err", 32'(err), 32'd1);
    chk("ovf_cnt", 32'(err_count), 32'd1);
    chk("ovf_novalid", 32'(out_valid), 32'd0);
    tick();
    chk("ovf_err_pulse", 32'(err), 32'd0);
    chk("ovf_cnt_hold", 32'(err_count), 32'd1);
    chk("ovf_novalid2", 32'(out_valid), 32'd0);

    // imm8 with backpressure
    out_ready = 1'b0;
    drive(4'h2, 4'h3, 4'h0, 16'hFF80);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_instr", 32'(out_instr), 32'h2380);
      chk("bp_addr", 32'(out_addr), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("bp_addr_next", 32'(out_addr), 32'd2);

    // address wrap over 257 words
    addr_clear = 1'b1;
    tick();
    addr_clear = 1'b0;
    chk("clr_idle", 32'(out_addr), 32'd0);
    for (int i = 0; i < 256; i++) begin
      opc = 4'($urandom);
      drive(opc, 4'($urandom), 4'($urandom), rnd_fit(opc));
    end
    drive(4'h9, 4'h4, 4'h5, 16'h0003);
    chk("wrap_addr", 32'(out_addr), 32'd0);
    chk("wrap_instr", 32'(out_instr), 32'h9453);
    tick();
    chk("wrap_next", 32'(out_addr), 32'd1);

    // clear coinciding with handshake
    out_ready = 1'b0;
    drive(4'h7, 4'h0, 4'h0, 16'hF800);
    chk("clrhs_addr", 32'(out_addr), 32'd1);
    tick();
    out_ready = 1'b1;
    addr_clear = 1'b1;
    tick();
    addr_clear = 1'b0;
    chk("clrhs_next", 32'(out_addr), 32'd0);
    drive(4'h1, 4'h6, 4'h0, 16'h007F);
    chk("clrhs_land", 32'(out_addr), 32'd0);
    tick();

    // error saturation
    cnt0 = err_seen;
    for (int i = 0; i < 300; i++)
      drive(4'h8, 4'h0, 4'h0, 16'h0008);
    chk("sat_err", 32'(err), 32'd1);
    tick();
    chk("sat_cnt", 32'(err_count), 32'd255);
    chk("sat_pulses", 32'(err_seen - cnt0), 32'd300);
    chk("sat_err_low", 32'(err), 32'd0);

    // reset during hold
    out_ready = 1'b0;
    drive(4'hA, 4'h1, 4'h1, 16'h0001);
    chk("hold_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rsth_valid", 32'(out_valid), 32'd0);
    chk("rsth_cnt", 32'(err_count), 32'd0);
    chk("rsth_addr", 32'(out_addr), 32'd0);
    chk("rsth_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    drive(4'h3, 4'h2, 4'h0, 16'h0010);
    chk("post_rst_instr", 32'(out_instr), 32'h3210);
    tick();
    tick();
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", ntest, nerr);
    $finish;
  end

endmodule
